// File: rtl/seg7_pkg.sv
// seg7_pkg: shared font table and display constants for the seven-segment scanner
package seg7_pkg;
  localparam logic [6:0] HEX_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF = 8'hFF;
endpackage

// File: rtl/hex7seg.sv
// hex7seg: combinational 4-bit to active-low {g..a} hex font lookup
module hex7seg
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = HEX_FONT[nib_i];
endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: eight-digit multiplexed hex display driver with per-frame snapshot
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int CLK_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] value,
  input  logic        blank_lz,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);
  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]    dig_q, dig_d;
  logic [31:0]   snap_q, snap_d;
  logic          first_q;
  logic          tick, blank;
  logic [3:0]    nib;
  logic [6:0]    font, seg_d;
  logic [7:0]    an_d;
  logic          dp_d;
  hex7seg u_font (.nib_i(nib), .seg_o(font));
  // next state and the outputs derived from it, so outputs track the updated digit
  always_comb begin
    tick      = div_cnt_q == DW'(CLK_DIV - 1);
    div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
    dig_d     = tick ? dig_q + 3'd1 : dig_q;
    snap_d    = (first_q || (tick && dig_q == 3'd7)) ? value : snap_q;
    nib       = snap_d[{dig_d, 2'b00} +: 4];
    blank     = blank_lz && dig_d != 3'd0 && (snap_d >> {dig_d, 2'b00}) == 32'd0;
    an_d      = (div_cnt_d == '0) ? AN_OFF : ~(8'd1 << dig_d);
    seg_d     = blank ? SEG_BLANK : font;
    dp_d      = ~dp_mask[dig_d];
  end
  // state and registered outputs; first forces a capture on the cycle after release
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt_q <= '0;
      dig_q     <= 3'd0;
      snap_q    <= 32'd0;
      first_q   <= 1'b1;
      an        <= AN_OFF;
      seg       <= SEG_BLANK;
      dp        <= 1'b1;
    end else begin
      div_cnt_q <= div_cnt_d;
      dig_q     <= dig_d;
      snap_q    <= snap_d;
      first_q   <= 1'b0;
      an        <= an_d;
      seg       <= seg_d;
      dp        <= dp_d;
    end
  end
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed self-checking bench for seg7_scan with CLK_DIV = 4
module tb_seg7_scan;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] value;
  logic        blank_lz;
  logic [7:0]  dp_mask;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  int n = 0;
  int fails = 0;
  logic [7:0] ea;
  logic       ed;
  logic [6:0] f_old [8] = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
  logic [6:0] f_dead [8] = '{7'h0E, 7'h06, 7'h06, 7'h03, 7'h21, 7'h08, 7'h06, 7'h21};
  logic [6:0] f_a05 [8] = '{7'h12, 7'h40, 7'h08, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
  logic [6:0] f_zero [8] = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
  logic [6:0] f_new [8] = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};

  seg7_scan #(.CLK_DIV(4)) dut (
    .clk(clk), .reset(reset), .value(value), .blank_lz(blank_lz),
    .dp_mask(dp_mask), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task test_reset;
    reset = 1'b0; value = 32'h12345678; blank_lz = 1'b0; dp_mask = 8'h00;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n++;
      if ({an, seg, dp} !== {8'hFF, 7'h7F, 1'b1}) begin
        fails++;
        $display("FAIL reset cyc=%0d got an=%h seg=%h dp=%b want FF/7F/1", i, an, seg, dp);
      end
    end
  endtask

  task test_normal_scan;
    reset = 1'b1;
    for (int d = 0; d < 8; d++) begin
      ea = ~(8'd1 << d);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        n++;
        if (an !== ea || seg !== f_old[d] || dp !== 1'b1) begin
          fails++;
          $display("FAIL normal d=%0d c=%0d got an=%h seg=%h dp=%b want an=%h seg=%h dp=1", d, c, an, seg, dp, ea, f_old[d]);
        end
      end
      @(negedge clk);
      n++;
      if (an !== 8'hFF) begin
        fails++;
        $display("FAIL normal_gap d=%0d got an=%h want FF", d, an);
      end
    end
  endtask

  task test_tear_free;
    for (int fr = 0; fr < 2; fr++) begin
      for (int d = 0; d < 8; d++) begin
        ea = ~(8'd1 << d);
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          n++;
          if (an !== ea || seg !== (fr == 0 ? f_old[d] : f_dead[d])) begin
            fails++;
            $display("FAIL tear fr=%0d d=%0d c=%0d got an=%h seg=%h want an=%h seg=%h", fr, d, c, an, seg, ea, fr == 0 ? f_old[d] : f_dead[d]);
          end
          if (fr == 0 && d == 3 && c == 0) value = 32'hDEADBEEF;
          if (fr == 1 && d == 0 && c == 0) begin value = 32'h00000A05; blank_lz = 1'b1; end
        end
        @(negedge clk);
        n++;
        if (an !== 8'hFF) begin
          fails++;
          $display("FAIL tear_gap fr=%0d d=%0d got an=%h want FF", fr, d, an);
        end
      end
    end
  endtask

  task test_leading_zero;
    for (int fr = 0; fr < 2; fr++) begin
      for (int d = 0; d < 8; d++) begin
        ea = ~(8'd1 << d);
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          n++;
          if (an !== ea || seg !== (fr == 0 ? f_a05[d] : f_zero[d])) begin
            fails++;
            $display("FAIL lz fr=%0d d=%0d c=%0d got an=%h seg=%h want an=%h seg=%h", fr, d, c, an, seg, ea, fr == 0 ? f_a05[d] : f_zero[d]);
          end
          if (fr == 0 && d == 7 && c == 2) value = 32'h0;
        end
        @(negedge clk);
        n++;
        if (an !== 8'hFF) begin
          fails++;
          $display("FAIL lz_gap fr=%0d d=%0d got an=%h want FF", fr, d, an);
        end
      end
    end
  endtask

  task test_decimal_point;
    dp_mask = 8'h04;
    for (int fr = 0; fr < 2; fr++) begin
      for (int d = 0; d < 8; d++) begin
        ea = ~(8'd1 << d);
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          ed = (fr == 0 || d < 3) ? (d != 2) : (d != 4);
          n++;
          if (an !== ea || dp !== ed || seg !== f_zero[d]) begin
            fails++;
            $display("FAIL dp fr=%0d d=%0d c=%0d got an=%h dp=%b seg=%h want an=%h dp=%b seg=%h", fr, d, c, an, dp, seg, ea, ed, f_zero[d]);
          end
          if (fr == 1 && d == 3 && c == 0) dp_mask = 8'h10;
        end
        @(negedge clk);
      end
    end
  endtask

  task test_mid_frame_reset;
    dp_mask = 8'h00; blank_lz = 1'b0;
    repeat (21) @(negedge clk);
    n++;
    if (an !== 8'hDF) begin
      fails++;
      $display("FAIL mid_pre got an=%h want DF", an);
    end
    reset = 1'b0;
    @(negedge clk);
    n++;
    if ({an, seg, dp} !== {8'hFF, 7'h7F, 1'b1}) begin
      fails++;
      $display("FAIL mid_reset got an=%h seg=%h dp=%b want FF/7F/1", an, seg, dp);
    end
    reset = 1'b1; value = 32'h87654321;
    for (int d = 0; d < 8; d++) begin
      ea = ~(8'd1 << d);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        n++;
        if (an !== ea || seg !== f_new[d] || dp !== 1'b1) begin
          fails++;
          $display("FAIL mid_restart d=%0d c=%0d got an=%h seg=%h dp=%b want an=%h seg=%h dp=1", d, c, an, seg, dp, ea, f_new[d]);
        end
      end
      @(negedge clk);
      n++;
      if (an !== 8'hFF) begin
        fails++;
        $display("FAIL mid_gap d=%0d got an=%h want FF", d, an);
      end
    end
  endtask

  initial begin
    test_reset;
    test_normal_scan;
    test_tear_free;
    test_leading_zero;
    test_decimal_point;
    test_mid_frame_reset;
    $display("[TB] %0d tests run, %0d failed", n, fails);
    $finish;
  end
endmodule
